frame_deser: RTL and testbench

Multi-channel, frame-synchronised serial-to-parallel converter: the parametrised successor of the single-bit `dgtop` deserialiser. It hunts for a sync pattern on channel 0, then assembles `NCH` lockstep serial bit streams into `WIDTH`-bit words for `FRAME_WORDS` words. Each word is presented after a `DELAY`-stage output pipeline. It sits directly behind the serial bit driver, in place of `dgtop` in the digital top.

---
 rtl/frame_deser_pkg.sv | 23 ++
 rtl/delay_pipe.sv | 43 ++++
 rtl/frame_deser.sv | 136 +++++++++++++
 tb/tb_frame_deser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_deser_pkg.sv
// Shared types and counter-width helpers for the frame deserialiser.
// Pure declarations; no latency or flow control of its own.
package frame_deser_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  // Widths are floored at 1 so degenerate parameter values still give legal vectors.
  function automatic int bit_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int word_cnt_w(input int frame_words);
    return (frame_words > 1) ? $clog2(frame_words) : 1;
  endfunction

  function automatic int fill_cnt_w(input int sync_len);
    return $clog2(sync_len + 1);
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// Fixed-depth valid/data register pipeline; DEPTH cycles of latency, DEPTH=0 is a wire.
// No backpressure: every valid input emerges DEPTH cycles later; data holds between valids.
module delay_pipe #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dat_i,
  input  logic          vld_i,
  output logic [DW-1:0] dat_o,
  output logic          vld_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dat_o = dat_i;
      assign vld_o = vld_i;
    end else begin : g_pipe
      logic [DW-1:0]    dat_q [DEPTH];
      logic [DEPTH-1:0] vld_q;

      // Data only advances alongside its valid so the last word stays parked at the output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= vld_i;
          if (vld_i) dat_q[0] <= dat_i;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign dat_o = dat_q[DEPTH-1];
      assign vld_o = vld_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/frame_deser.sv
// Sync-hunting NCH-channel serial-to-parallel converter; word out 1+DELAY cycles after its last bit.
// No backpressure: in_valid gaps stall assembly, the output pipeline never stalls or drops.
module frame_deser
  import frame_deser_pkg::*;
#(
  parameter int                  WIDTH       = 4,
  parameter int                  DELAY       = 2,
  parameter int                  NCH         = 2,
  parameter int                  SYNC_LEN    = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT    = SYNC_LEN'(8'hA5),
  parameter int                  FRAME_WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       ctrl,
  input  logic                 in_valid,
  input  logic                 msb_first,
  output logic [NCH*WIDTH-1:0] out,
  output logic                 enable,
  output logic                 frame_done,
  output logic                 hunting
);

  localparam int BCW = bit_cnt_w(WIDTH);
  localparam int WCW = word_cnt_w(FRAME_WORDS);
  localparam int FCW = fill_cnt_w(SYNC_LEN);
  localparam int DW  = NCH * WIDTH;

  state_t              state_q, state_d;
  logic [SYNC_LEN-1:0] sreg_q, sreg_d, sreg_shift;
  logic [FCW-1:0]      fill_q, fill_d, fill_inc;
  logic [BCW-1:0]      bitcnt_q, bitcnt_d;
  logic [WCW-1:0]      wordcnt_q, wordcnt_d;
  logic                msb_q, msb_d;
  logic [DW-1:0]       asm_q, asm_d;
  logic [DW-1:0]       cap_dat_q, cap_dat_d;
  logic                cap_vld_q, cap_vld_d;
  logic                cap_last_q, cap_last_d;
  logic                last_o;
  int                  pos;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    fill_d     = fill_q;
    bitcnt_d   = bitcnt_q;
    wordcnt_d  = wordcnt_q;
    msb_d      = msb_q;
    asm_d      = asm_q;
    cap_dat_d  = cap_dat_q;
    cap_vld_d  = 1'b0;
    cap_last_d = cap_last_q;
    pos        = msb_q ? (WIDTH - 1 - int'(bitcnt_q)) : int'(bitcnt_q);
    sreg_shift = (sreg_q << 1) | SYNC_LEN'(ctrl[0]);
    fill_inc   = (fill_q == FCW'(SYNC_LEN)) ? fill_q : fill_q + 1'b1;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (fill_inc == FCW'(SYNC_LEN) && sreg_shift == SYNC_PAT) begin
            state_d   = DATA;
            msb_d     = msb_first;
            bitcnt_d  = '0;
            wordcnt_d = '0;
            sreg_d    = '0;
            fill_d    = '0;
          end else begin
            sreg_d = sreg_shift;
            fill_d = fill_inc;
          end
        end
        DATA: begin
          for (int c = 0; c < NCH; c++) asm_d[c*WIDTH + pos] = ctrl[c];
          if (bitcnt_q == BCW'(WIDTH - 1)) begin
            cap_dat_d  = asm_d;
            cap_vld_d  = 1'b1;
            cap_last_d = (wordcnt_q == WCW'(FRAME_WORDS - 1));
            bitcnt_d   = '0;
            if (wordcnt_q == WCW'(FRAME_WORDS - 1)) begin
              wordcnt_d = '0;
              state_d   = HUNT;
            end else begin
              wordcnt_d = wordcnt_q + 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sreg_q     <= '0;
      fill_q     <= '0;
      bitcnt_q   <= '0;
      wordcnt_q  <= '0;
      msb_q      <= 1'b0;
      asm_q      <= '0;
      cap_dat_q  <= '0;
      cap_vld_q  <= 1'b0;
      cap_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      fill_q     <= fill_d;
      bitcnt_q   <= bitcnt_d;
      wordcnt_q  <= wordcnt_d;
      msb_q      <= msb_d;
      asm_q      <= asm_d;
      cap_dat_q  <= cap_dat_d;
      cap_vld_q  <= cap_vld_d;
      cap_last_q <= cap_last_d;
    end
  end

  // The frame-last flag rides with the word so frame_done lines up with its enable.
  delay_pipe #(
    .DW    (DW + 1),
    .DEPTH (DELAY)
  ) u_delay_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .dat_i ({cap_last_q, cap_dat_q}),
    .vld_i (cap_vld_q),
    .dat_o ({last_o, out}),
    .vld_o (enable)
  );

  assign frame_done = enable & last_o;
  assign hunting    = (state_q == HUNT);

endmodule

// File: tb/tb_frame_deser.sv
// Directed bench for frame_deser in its default 4-bit, 2-channel, A5-sync, 2-word, DELAY=2 setup.
module tb_frame_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       msb_first = 1'b1;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] dout;
  logic       enable, frame_done, hunting;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cnt = 0, fd_cnt = 0, fd_idx = 0, fd_orphan = 0, en_cyc = 0, en_prev_cyc = 0;

  frame_deser #(
    .WIDTH(4), .DELAY(2), .NCH(2), .SYNC_LEN(8), .SYNC_PAT(8'hA5), .FRAME_WORDS(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (ctrl),
    .in_valid   (in_valid),
    .msb_first  (msb_first),
    .out        (dout),
    .enable     (enable),
    .frame_done (frame_done),
    .hunting    (hunting)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enable === 1'b1) begin
      en_cnt      = en_cnt + 1;
      en_prev_cyc = en_cyc;
      en_cyc      = cyc;
      if (frame_done === 1'b1) begin
        fd_cnt = fd_cnt + 1;
        fd_idx = en_cnt;
      end
    end else if (frame_done === 1'b1) begin
      fd_orphan = fd_orphan + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input logic v, input logic c0, input logic c1);
    @(negedge clk);
    in_valid = v;
    ctrl     = {c1, c0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ctrl     = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_sync(input int gap_at, input int gap_len);
    logic [7:0] p;
    p = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      if (7 - i == gap_at) repeat (gap_len) step(1'b0, 1'b1, 1'b1);
      step(1'b1, p[i], i[0]);
    end
  endtask

  task automatic send_word(input logic [3:0] b0, input logic [3:0] b1, input int gap_at, input int gap_len);
    for (int i = 3; i >= 0; i--) begin
      if (3 - i == gap_at) repeat (gap_len) step(1'b0, 1'b1, 1'b1);
      step(1'b1, b0[i], b1[i]);
    end
  endtask

  task automatic wait_en(output int at, output bit seen);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (enable === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl = i[0] ? 2'b11 : 2'b00;
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", dout); end
      checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      checks++; if (hunting !== 1'b1) begin errors++; $display("FAIL reset_hunting: got %b expected 1", hunting); end
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_msb_word();
    int t0, at;
    bit seen;
    do_reset();
    msb_first = 1'b1;
    t0 = cyc;
    send_sync(-1, 0);
    checks++; if (hunting !== 1'b1) begin errors++; $display("FAIL msb_hunt_before_match: got %b expected 1", hunting); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (hunting !== 1'b0) begin errors++; $display("FAIL msb_hunt_fall: got %b expected 0", hunting); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    wait_en(at, seen);
    checks++; if (!seen) begin errors++; $display("FAIL msb_enable_timeout: got none expected enable"); end
    checks++; if (at - t0 != 15) begin errors++; $display("FAIL msb_latency: got %0d expected 15", at - t0); end
    checks++; if (dout !== 8'h3B) begin errors++; $display("FAIL msb_out: got %h expected 3b", dout); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL msb_frame_done: got %b expected 0", frame_done); end
    @(negedge clk);
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL msb_enable_pulse: got %b expected 0", enable); end
    checks++; if (dout !== 8'h3B) begin errors++; $display("FAIL msb_out_hold: got %h expected 3b", dout); end
  endtask

  task automatic test_lsb_word();
    int at;
    bit seen;
    do_reset();
    msb_first = 1'b0;
    send_sync(-1, 0);
    step(1'b1, 1'b1, 1'b0);
    msb_first = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    wait_en(at, seen);
    checks++; if (!seen || dout !== 8'hCD) begin errors++; $display("FAIL lsb_out: got %h expected cd", dout); end
    send_word(4'b1000, 4'b0001, -1, 0);
    wait_en(at, seen);
    checks++; if (!seen || dout !== 8'h81) begin errors++; $display("FAIL lsb_latched_order: got %h expected 81", dout); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL lsb_frame_done: got %b expected 1", frame_done); end
  endtask

  task automatic test_gaps();
    int t0, at;
    bit seen;
    do_reset();
    msb_first = 1'b1;
    t0 = cyc;
    send_sync(4, 3);
    send_word(4'b1011, 4'b0011, -1, 0);
    wait_en(at, seen);
    checks++; if (at - t0 != 18) begin errors++; $display("FAIL gap_sync_latency: got %0d expected 18", at - t0); end
    checks++; if (dout !== 8'h3B) begin errors++; $display("FAIL gap_sync_out: got %h expected 3b", dout); end
    do_reset();
    t0 = cyc;
    send_sync(-1, 0);
    send_word(4'b1011, 4'b0011, 2, 3);
    wait_en(at, seen);
    checks++; if (at - t0 != 18) begin errors++; $display("FAIL gap_word_latency: got %0d expected 18", at - t0); end
    checks++; if (dout !== 8'h3B) begin errors++; $display("FAIL gap_word_out: got %h expected 3b", dout); end
  endtask

  task automatic test_frame_end();
    int e0, f0, o0, at;
    bit seen;
    logic [7:0] x;
    logic [8:0] s;
    x = 8'b0000_1111;
    s = 9'b0_1010_0101;
    do_reset();
    msb_first = 1'b1;
    e0 = en_cnt; f0 = fd_cnt; o0 = fd_orphan;
    send_sync(-1, 0);
    send_word(4'b1011, 4'b0011, -1, 0);
    send_word(4'b0110, 4'b1001, -1, 0);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, x[i], ~x[i]);
      if (i == 7) begin
        checks++; if (hunting !== 1'b1) begin errors++; $display("FAIL frame_end_hunting: got %b expected 1", hunting); end
      end
    end
    #1;
    checks++; if (en_cnt - e0 != 2) begin errors++; $display("FAIL frame_end_enables: got %0d expected 2", en_cnt - e0); end
    checks++; if (fd_cnt - f0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_cnt - f0); end
    checks++; if (fd_idx != e0 + 2) begin errors++; $display("FAIL frame_done_align: got %0d expected %0d", fd_idx, e0 + 2); end
    checks++; if (fd_orphan != o0) begin errors++; $display("FAIL frame_done_orphan: got %0d expected %0d", fd_orphan, o0); end
    checks++; if (en_cyc - en_prev_cyc != 4) begin errors++; $display("FAIL back_to_back_spacing: got %0d expected 4", en_cyc - en_prev_cyc); end
    checks++; if (dout !== 8'h96) begin errors++; $display("FAIL frame_end_out: got %h expected 96", dout); end
    for (int i = 8; i >= 0; i--) step(1'b1, s[i], 1'b0);
    checks++; if (hunting !== 1'b1) begin errors++; $display("FAIL slide_no_early_match: got %b expected 1", hunting); end
    step(1'b1, 1'b0, 1'b1);
    checks++; if (hunting !== 1'b0) begin errors++; $display("FAIL slide_sync: got %b expected 0", hunting); end
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    wait_en(at, seen);
    checks++; if (!seen || dout !== 8'hF5) begin errors++; $display("FAIL slide_out: got %h expected f5", dout); end
    #1;
    checks++; if (en_cnt - e0 != 3) begin errors++; $display("FAIL slide_enables: got %0d expected 3", en_cnt - e0); end
  endtask

  task automatic test_reset_pipe();
    int e0;
    do_reset();
    msb_first = 1'b1;
    e0 = en_cnt;
    send_sync(-1, 0);
    send_word(4'b1011, 4'b0011, -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (hunting !== 1'b1) begin errors++; $display("FAIL rstpipe_hunting_low: got %b expected 1", hunting); end
    @(negedge clk);
    rst_n = 1'b1;
    send_word(4'b1011, 4'b0011, -1, 0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (en_cnt != e0) begin errors++; $display("FAIL rstpipe_no_enable: got %0d expected %0d", en_cnt - e0, 0); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstpipe_out: got %h expected 00", dout); end
    checks++; if (hunting !== 1'b1) begin errors++; $display("FAIL rstpipe_hunting: got %b expected 1", hunting); end
  endtask

  initial begin
    test_reset();
    test_msb_word();
    test_lsb_word();
    test_gaps();
    test_frame_end();
    test_reset_pipe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
